dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequencer and arbiter in front of the word-only, single-port data memory (combinational read, posedge write, word index = addr[9:2]).
- Shares the memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug).
- Converts byte/halfword loads into word reads with lane extract and sign/zero extension.
- Converts byte/halfword stores into read-modify-write sequences.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- DEPTH_LOG2, 8: log2 of memory depth in words; byte address limit = 4 << DEPTH_LOG2 (1024).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request, held stable until that port's done
- req_we  in  2  per-port 1=store, 0=load
- req_size0, req_size1  in  2 each  00 byte, 01 half, 10 word, 11 reserved (treated as error)
- req_unsigned  in  2  per-port load zero-extend (1) / sign-extend (0)
- req_addr0, req_addr1  in  32 each  byte address
- req_wdata0, req_wdata1  in  32 each  store data, right-aligned (byte in [7:0], half in [15:0])
- done  out  2  one-cycle completion pulse for the served port
- err  out  1  valid with done; misaligned, out-of-range or reserved size
- rdata  out  32  extended load data, valid with done; 0 for stores and errors
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  32  word-aligned address, addr[1:0] forced to 00
- mem_wdata  out  32  word written to memory
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, MERGE_WR, RESP. Memory strobes are decoded from state and latched fields only, never from live requester inputs.
- Reset (async): state=IDLE, last_grant=1, done=0, err=0, rdata=0, latched fields=0. mem_read/mem_write drop to 0 immediately. A reset during MERGE_WR aborts the write; no done is issued.
- IDLE:
  - No valid requests: stay in IDLE.
  - One valid request: grant it.
  - Both valid: grant the port != last_grant (round-robin); first grant after reset goes to port 0.
  - On grant, latch port id, we, size, unsigned, addr, wdata; update last_grant; go to ACCESS.
- Error check (latched fields), any one sets err:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - size=11
  - addr >= 4<<DEPTH_LOG2
- ACCESS:
  - Error: no strobes; err_r=1, rdata_r=0; go to RESP.
  - Load: mem_read=1; capture lane mem_rdata[8*addr[1:0] +: 8] (byte) or [16*addr[1] +: 16] (half), extend per unsigned, into rdata_r; go to RESP.
  - Word store: mem_write=1, mem_wdata=wdata; go to RESP.
  - Byte/half store: mem_read=1; capture the word with the addressed lane replaced by wdata's low bits into merge_r; go to MERGE_WR.
- MERGE_WR: mem_write=1, mem_wdata=merge_r; go to RESP.
- RESP: done[port]=1 for one cycle with err/rdata valid; go to IDLE. Outside RESP, done=0.
- Latency, request first seen in IDLE at cycle 0:
  - done in cycle 2 for loads, word stores and errors.
  - done in cycle 3 for sub-word stores.
  - The other port waits at most 4 cycles once queued.
- Requester rules:
  - Drop valid in the cycle after done unless issuing a new request. A held valid is sampled in the next IDLE as a new request.
  - Changes to a port's inputs after grant have no effect on the in-flight access.
- Only one access is ever in flight. No memory strobe is asserted in IDLE or RESP.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state typedef
  - function lane_extract(word, addr_lo, size, unsigned)
  - function lane_merge(word, addr_lo, size, wdata)
- One natural sub-module: dmem_rr_arb (2-way round-robin grant with last_grant register).

Test Plan:
- Load after reset: mem[2]=0x8899AABB; port0 lb addr 0x9, signed -> done[0] in cycle 2, rdata=0xFFFFFFAA, err=0; lbu same address -> 0x000000AA.
- Sub-word store: mem[1]=0x11223344; port1 sh addr 0x6, wdata 0x0000BEEF -> mem_read in ACCESS, mem_write with 0xBEEF3344 in MERGE_WR, done[1] at cycle 3.
- Contention: both ports request word loads every cycle -> grants alternate 0,1,0,1; each done exactly once per grant; never both done bits set.
- Errors: lw addr 0x6, sh addr 0x3, sw addr 0x400, size=11 -> err=1, rdata=0, mem_read=mem_write=0 throughout; done at cycle 2.
- Reset mid-RMW: assert rst_n=0 during MERGE_WR -> mem_write falls without a clock edge, memory unchanged; after release, state=IDLE, a contended request goes to port 0.
- Input change after grant: port0 alters addr/wdata in ACCESS -> written address/data equal the values latched at grant.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings, FSM state type and lane helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_MERGE_WR = 2'd2,
        ST_RESP     = 2'd3
    } dmem_state_e;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{addr_lo, 3'b000} +: 8]    = wdata[7:0];
            SZ_HALF: r[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  req_size0;
    logic [1:0]  req_size1;
    logic [1:0]  req_unsigned;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size0, req_size1, req_unsigned,
               req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        output done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size0, req_size1, req_unsigned,
               req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        input  done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb.sv
// Two-way round-robin grant; last_grant resets to 1 so the first contended grant is port 0.
module dmem_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_valid,
    output logic       gnt_port
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_valid    = |req;
        gnt_port     = 1'b0;
        last_grant_d = last_grant_q;
        case (req)
            2'b01:   gnt_port = 1'b0;
            2'b10:   gnt_port = 1'b1;
            2'b11:   gnt_port = ~last_grant_q;
            default: gnt_port = 1'b0;
        endcase
        if (grant_en && gnt_valid) begin
            last_grant_d = gnt_port;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer in front of a word-only single-port data memory.
// state       | meaning
// ST_IDLE     | waiting for a request, grant and latch fields
// ST_ACCESS   | error check, load, word store, or RMW read
// ST_MERGE_WR | write back merged word of a sub-word store
// ST_RESP     | one-cycle done pulse with err/rdata
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [31:0] ADDR_LIMIT = 32'd4 << DEPTH_LOG2;

    dmem_state_e state_q, state_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        gnt_valid;
    logic        gnt_port;
    logic        acc_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;

    dmem_rr_arb u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .grant_en  (state_q == ST_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // Evaluated only on latched fields so requester changes after grant are invisible.
    assign acc_err = ((size_q == SZ_HALF) && addr_q[0])
                   || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
                   || (size_q == SZ_RSVD)
                   || (addr_q >= ADDR_LIMIT);

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    port_d  = gnt_port;
                    we_d    = bus.req_we[gnt_port];
                    uns_d   = bus.req_unsigned[gnt_port];
                    size_d  = gnt_port ? bus.req_size1  : bus.req_size0;
                    addr_d  = gnt_port ? bus.req_addr1  : bus.req_addr0;
                    wdata_d = gnt_port ? bus.req_wdata1 : bus.req_wdata0;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (acc_err) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = ST_RESP;
                end else if (!we_q) begin
                    mem_read = 1'b1;
                    rdata_d  = lane_extract(bus.mem_rdata, addr_q[1:0], size_q, uns_q);
                    state_d  = ST_RESP;
                end else if (size_q == SZ_WORD) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = ST_RESP;
                end else begin
                    mem_read = 1'b1;
                    merge_d  = lane_merge(bus.mem_rdata, addr_q[1:0], size_q, wdata_q);
                    state_d  = ST_MERGE_WR;
                end
            end
            ST_MERGE_WR: begin
                mem_write = 1'b1;
                mem_wdata = merge_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.done      = (state_q == ST_RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.err       = (state_q == ST_RESP) && err_q;
    assign bus.rdata     = (state_q == ST_RESP) ? rdata_q : 32'h0;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected responses/writes, a monitor pops and compares.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.DEPTH_LOG2(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_done   = 0;
    logic  err_txn  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: responses, memory writes, and strobe silence during error accesses.
    always @(negedge clk) begin
        if (bus.done != 2'b00) begin
            resp_t e;
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=%b with nothing expected", bus.done);
            end else begin
                e = exp_q.pop_front();
                chk("done_port", {30'h0, bus.done}, e.port ? 32'h2 : 32'h1);
                chk("err", {31'h0, bus.err}, {31'h0, e.err});
                chk("rdata", bus.rdata, e.rdata);
                chk("done_cycle", cyc, e.cyc);
            end
        end
        if (bus.mem_write) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", bus.mem_addr, w.addr);
                chk("wr_data", bus.mem_wdata, w.data);
            end
        end
        if (err_txn) chk("no_strobe_on_err", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    end

    task automatic drive(input logic p, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.req_we[p]       = we;
        bus.req_unsigned[p] = uns;
        if (p) begin
            bus.req_size1  = sz;
            bus.req_addr1  = addr;
            bus.req_wdata1 = wd;
        end else begin
            bus.req_size0  = sz;
            bus.req_addr0  = addr;
            bus.req_wdata0 = wd;
        end
        bus.req_valid[p] = 1'b1;
    endtask

    task automatic wait_done(input logic p, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (bus.done[p]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done on port %0d within 12 cycles", name, p);
        end
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic txn(input string name, input logic p, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input int lat);
        @(posedge clk); #1;
        drive(p, we, sz, uns, addr, wd);
        exp_q.push_back('{p, exp_err, exp_rd, cyc + lat});
        wait_done(p, name);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int target;
        bit got;

        pre_en = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
        bus.req_valid = 2'b00; bus.req_we = 2'b00; bus.req_unsigned = 2'b00;
        bus.req_size0 = 2'b00; bus.req_size1 = 2'b00;
        bus.req_addr0 = 32'h0; bus.req_addr1 = 32'h0;
        bus.req_wdata0 = 32'h0; bus.req_wdata1 = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", {30'h0, bus.done}, 32'h0);
        chk("reset_err", {31'h0, bus.err}, 32'h0);
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        rst_n = 1'b1;

        // Loads with lane extract and extension
        preload(8'd2, 32'h8899AABB);
        txn("lb",   1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 1'b0, 32'hFFFFFFAA, 2);
        txn("lbu",  1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 1'b0, 32'h000000AA, 2);
        txn("lh",   1'b0, 1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0, 1'b0, 32'hFFFF8899, 2);
        txn("lhu",  1'b1, 1'b0, SZ_HALF, 1'b1, 32'h8, 32'h0, 1'b0, 32'h0000AABB, 2);
        txn("lw",   1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0, 32'h8899AABB, 2);
        txn("lbu3", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0, 1'b0, 32'h00000088, 2);

        // Sub-word and word stores
        preload(8'd1, 32'h11223344);
        wr_q.push_back('{32'h4, 32'hBEEF3344});
        txn("sh", 1'b1, 1'b1, SZ_HALF, 1'b0, 32'h6, 32'h0000BEEF, 1'b0, 32'h0, 3);
        chk("mem1_after_sh", mem[1], 32'hBEEF3344);
        wr_q.push_back('{32'h4, 32'h5AEF3344});
        txn("sb", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h7, 32'hFFFFFF5A, 1'b0, 32'h0, 3);
        chk("mem1_after_sb", mem[1], 32'h5AEF3344);
        wr_q.push_back('{32'h10, 32'hCAFEF00D});
        txn("sw", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0, 2);
        txn("lw_back", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D, 2);

        // Last in-range word, then error cases
        preload(8'd255, 32'h0BADCAFE);
        txn("lw_top", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0BADCAFE, 2);
        err_txn = 1'b1;
        txn("err_lw_mis", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h6,   32'h0,        1'b1, 32'h0, 2);
        txn("err_sh_mis", 1'b1, 1'b1, SZ_HALF, 1'b0, 32'h3,   32'h1234,     1'b1, 32'h0, 2);
        txn("err_sw_oor", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h400, 32'h77777777, 1'b1, 32'h0, 2);
        txn("err_rsvd",   1'b1, 1'b0, SZ_RSVD, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0, 2);
        err_txn = 1'b0;

        // Requester changes after grant must not affect the access
        wr_q.push_back('{32'h20, 32'h12345678});
        @(posedge clk); #1;
        drive(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678);
        exp_q.push_back('{1'b0, 1'b0, 32'h0, cyc + 2});
        @(posedge clk); #1;
        bus.req_addr0 = 32'h24; bus.req_wdata0 = 32'hDEADBEEF;
        wait_done(1'b0, "chg_sw");
        chk("mem8_after_chg_sw", mem[8], 32'h12345678);

        wr_q.push_back('{32'h20, 32'hAAAA5678});
        @(posedge clk); #1;
        drive(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000AAAA);
        exp_q.push_back('{1'b0, 1'b0, 32'h0, cyc + 3});
        @(posedge clk); #1;
        bus.req_addr0 = 32'h0; bus.req_wdata0 = 32'h00005555;
        wait_done(1'b0, "chg_sh");
        chk("mem8_after_chg_sh", mem[8], 32'hAAAA5678);

        // Reset while the merged write is on the bus
        preload(8'd7, 32'h01020304);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h1C, 32'h000000FF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rmw_write_before_reset", {31'h0, bus.mem_write}, 32'h1);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        chk("rmw_write_after_reset", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        chk("rmw_done_after_reset", {30'h0, bus.done}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("mem7_unchanged", mem[7], 32'h01020304);
        rst_n = 1'b1;

        // Contention: both ports hold word loads; grants alternate starting at port 0
        preload(8'd5, 32'h55550005);
        preload(8'd6, 32'h66660006);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0);
        k = cyc;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{((i % 2) == 1), 1'b0,
                              ((i % 2) == 1) ? 32'h66660006 : 32'h55550005,
                              k + 2 + 3 * i});
        end
        target = n_done + 6;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            if (n_done >= target) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL contention_timeout: %0d of 6 responses seen", n_done - target + 6);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;

        repeat (6) @(posedge clk);
        #1;
        chk("responses_outstanding", exp_q.size(), 32'h0);
        chk("writes_outstanding", wr_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
